fifo_sync_param: RTL and testbench

//  Parametrised single-clock FIFO; next-generation DUT behind fifo_interface.

---
 rtl/fifo_sync_param.sv | 101 ++++++++++
 tb/tb_fifo_sync_param.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with runtime almost-full/almost-empty thresholds,
// fill level, sticky overflow/underflow flags and an optional first-word-fall-through read port.
module fifo_sync_param #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned FWFT   = 0,
    parameter int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_wren,
    input  logic [DATA_W-1:0] i_wrdata,
    input  logic              i_rden,
    input  logic [AW:0]       i_alm_full_th,
    input  logic [AW:0]       i_alm_empty_th,
    input  logic              i_clr_err,
    output logic [DATA_W-1:0] o_rddata,
    output logic              o_rdvalid,
    output logic              o_full,
    output logic              o_alm_full,
    output logic              o_empty,
    output logic              o_alm_empty,
    output logic [AW:0]       o_count,
    output logic              o_overflow,
    output logic              o_underflow
);

    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              rd_ok;
    logic              wr_ok;

    // A write into a full FIFO is accepted only when the same cycle pops a word.
    assign rd_ok = i_rden & ~o_empty;
    assign wr_ok = i_wren & (~o_full | rd_ok);

    assign o_count     = count;
    assign o_full      = (count == CW'(DEPTH));
    assign o_empty     = (count == '0);
    assign o_alm_full  = (count >= i_alm_full_th);
    assign o_alm_empty = (count <= i_alm_empty_th);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(wr_ok) - CW'(rd_ok);
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= i_wrdata;
    end

    // Sticky error flags; a new error event wins over a clear in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (i_wren & o_full & ~rd_ok) o_overflow <= 1'b1;
            else if (i_clr_err)           o_overflow <= 1'b0;
            if (i_rden & o_empty)         o_underflow <= 1'b1;
            else if (i_clr_err)           o_underflow <= 1'b0;
        end
    end

    generate
        if (FWFT == 0) begin : g_reg_read
            logic [DATA_W-1:0] rddata_q;
            logic              rdvalid_q;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    rddata_q  <= '0;
                    rdvalid_q <= 1'b0;
                end else begin
                    rdvalid_q <= rd_ok;
                    if (rd_ok) rddata_q <= mem[rd_ptr];
                end
            end

            assign o_rddata  = rddata_q;
            assign o_rdvalid = rdvalid_q;
        end else begin : g_fwft_read
            // Head word is presented directly; zero while empty so reset shows 0.
            assign o_rddata  = o_empty ? '0 : mem[rd_ptr];
            assign o_rdvalid = ~o_empty;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param: registered-read and FWFT instances share stimulus and
// are compared every cycle against a queue-based model of the FIFO.
module tb_fifo_sync_param;

    localparam int unsigned DW = 128;
    localparam int unsigned DP = 16;
    localparam int unsigned AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          wren;
    logic [DW-1:0] wrdata;
    logic          rden;
    logic [AW:0]   alm_full_th;
    logic [AW:0]   alm_empty_th;
    logic          clr_err;

    logic [DW-1:0] rddata0, rddata1;
    logic          rdvalid0, rdvalid1;
    logic          full0, full1, alm_full0, alm_full1;
    logic          empty0, empty1, alm_empty0, alm_empty1;
    logic [AW:0]   count0, count1;
    logic          ovf0, ovf1, udf0, udf1;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] m_rd0;
    logic          m_rv0;
    logic          m_ovf;
    logic          m_udf;

    always #5 clk = ~clk;

    fifo_sync_param #(.DATA_W(DW), .DEPTH(DP), .FWFT(0)) u_dut0 (
        .clk(clk), .reset(reset), .i_wren(wren), .i_wrdata(wrdata), .i_rden(rden),
        .i_alm_full_th(alm_full_th), .i_alm_empty_th(alm_empty_th), .i_clr_err(clr_err),
        .o_rddata(rddata0), .o_rdvalid(rdvalid0), .o_full(full0), .o_alm_full(alm_full0),
        .o_empty(empty0), .o_alm_empty(alm_empty0), .o_count(count0),
        .o_overflow(ovf0), .o_underflow(udf0)
    );

    fifo_sync_param #(.DATA_W(DW), .DEPTH(DP), .FWFT(1)) u_dut1 (
        .clk(clk), .reset(reset), .i_wren(wren), .i_wrdata(wrdata), .i_rden(rden),
        .i_alm_full_th(alm_full_th), .i_alm_empty_th(alm_empty_th), .i_clr_err(clr_err),
        .o_rddata(rddata1), .o_rdvalid(rdvalid1), .o_full(full1), .o_alm_full(alm_full1),
        .o_empty(empty1), .o_alm_empty(alm_empty1), .o_count(count1),
        .o_overflow(ovf1), .o_underflow(udf1)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int n;
        logic [DW-1:0] head;
        n = q.size();
        head = (n > 0) ? q[0] : '0;
        chk("count0", DW'(count0), DW'(n));
        chk("count1", DW'(count1), DW'(n));
        chk("full0", DW'(full0), DW'(n == DP));
        chk("full1", DW'(full1), DW'(n == DP));
        chk("empty0", DW'(empty0), DW'(n == 0));
        chk("empty1", DW'(empty1), DW'(n == 0));
        chk("alm_full0", DW'(alm_full0), DW'(n >= int'(alm_full_th)));
        chk("alm_full1", DW'(alm_full1), DW'(n >= int'(alm_full_th)));
        chk("alm_empty0", DW'(alm_empty0), DW'(n <= int'(alm_empty_th)));
        chk("alm_empty1", DW'(alm_empty1), DW'(n <= int'(alm_empty_th)));
        chk("ovf0", DW'(ovf0), DW'(m_ovf));
        chk("ovf1", DW'(ovf1), DW'(m_ovf));
        chk("udf0", DW'(udf0), DW'(m_udf));
        chk("udf1", DW'(udf1), DW'(m_udf));
        chk("rddata0", rddata0, m_rd0);
        chk("rdvalid0", DW'(rdvalid0), DW'(m_rv0));
        chk("rddata1", rddata1, head);
        chk("rdvalid1", DW'(rdvalid1), DW'(n != 0));
    endtask

    // One clock of stimulus; the model advances on the same edge as the DUT.
    task automatic step(input logic wr, input logic [DW-1:0] d, input logic rd, input logic clr);
        int  n;
        bit  rok;
        bit  wok;
        wren = wr; wrdata = d; rden = rd; clr_err = clr;
        @(posedge clk);
        n   = q.size();
        rok = rd && (n > 0);
        wok = wr && ((n < DP) || rok);
        if (wr && (n == DP) && !rok) m_ovf = 1'b1;
        else if (clr)                m_ovf = 1'b0;
        if (rd && (n == 0))          m_udf = 1'b1;
        else if (clr)                m_udf = 1'b0;
        m_rv0 = rok;
        if (rok) m_rd0 = q.pop_front();
        if (wok) q.push_back(d);
        #1;
        check_all();
    endtask

    task automatic model_reset();
        q.delete();
        m_rd0 = '0; m_rv0 = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    endtask

    function automatic logic [DW-1:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        reset = 1'b0; wren = 1'b0; wrdata = '0; rden = 1'b0; clr_err = 1'b0;
        alm_full_th = 5'd14; alm_empty_th = 5'd2;
        model_reset();
        #2;
        check_all();
        chk("rst_alm_empty", DW'(alm_empty0), DW'(1));
        @(posedge clk); #1 reset = 1'b1;

        // Fill ramp, overflow on the 17th write.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, DW'(i), 1'b0, 1'b0);
            if (i == 13) chk("t1_alm_full_at14", DW'(alm_full0), DW'(1));
        end
        chk("t1_full", DW'(full0), DW'(1));
        step(1'b1, DW'(99), 1'b0, 1'b0);
        chk("t1_overflow", DW'(ovf0), DW'(1));
        chk("t1_count16", DW'(count0), DW'(16));

        // Drain 16 with registered read data, then one extra read.
        for (int i = 0; i < 16; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            chk("t2_data", rddata0, DW'(i));
        end
        step(1'b0, '0, 1'b1, 1'b0);
        chk("t2_underflow", DW'(udf0), DW'(1));
        chk("t2_no_rdvalid", DW'(rdvalid0), DW'(0));

        // Clear sticky errors.
        step(1'b0, '0, 1'b0, 1'b1);
        chk("t6_ovf_clr", DW'(ovf0), DW'(0));
        chk("t6_udf_clr", DW'(udf0), DW'(0));

        // Full with simultaneous read and write across several pointer wraps.
        for (int i = 0; i < 16; i++) step(1'b1, rnd128(), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b1, rnd128(), 1'b1, 1'b0);
        chk("t3_no_ovf", DW'(ovf0), DW'(0));
        chk("t3_count16", DW'(count0), DW'(16));
        for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1, 1'b0);

        // FWFT head visible the cycle after writing into an empty FIFO.
        step(1'b1, DW'(8'hA5), 1'b0, 1'b0);
        chk("t4_fwft_data", rddata1, DW'(8'hA5));
        chk("t4_fwft_valid", DW'(rdvalid1), DW'(1));
        step(1'b0, '0, 1'b1, 1'b0);
        chk("t4_fwft_empty", DW'(empty1), DW'(1));

        // Asynchronous reset at count 9.
        for (int i = 0; i < 9; i++) step(1'b1, rnd128(), 1'b0, 1'b0);
        chk("t5_count9", DW'(count0), DW'(9));
        wren = 1'b0; rden = 1'b0;
        #2 reset = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk); #1 reset = 1'b1;
        step(1'b1, DW'(32'hCAFE_F00D), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("t5_first_read", rddata0, DW'(32'hCAFE_F00D));

        // Threshold above depth keeps almost-full low even when full.
        alm_full_th = 5'd17;
        for (int i = 0; i < 16; i++) step(1'b1, rnd128(), 1'b0, 1'b0);
        chk("t6_th17_full", DW'(full0), DW'(1));
        chk("t6_th17_alm_full", DW'(alm_full0), DW'(0));

        // Random traffic with changing thresholds and occasional error clears.
        for (int i = 0; i < 400; i++) begin
            alm_full_th  = 5'($urandom_range(0, 18));
            alm_empty_th = 5'($urandom_range(0, 18));
            step(1'($urandom_range(0, 1)), rnd128(), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 7) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
